// File: rtl/vga.sv
// VGA timing generator: 25 MHz pixel tick derived from a 50 MHz clock, free-running
// h/v counters, registered active-low syncs and a solid colour over the visible area.
module vga #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic       phase_reg;
  logic       pixel_tick;
  logic [9:0] h_count_reg, h_count_next;
  logic [9:0] v_count_reg, v_count_next;
  logic       hsync_next, vsync_next;
  logic       video_on;
  logic [2:0] rgb_next;

  assign pixel_tick = phase_reg;

  always_comb begin
    h_count_next = h_count_reg;
    v_count_next = v_count_reg;
    if (pixel_tick) begin
      if (h_count_reg == H_LAST) begin
        h_count_next = '0;
        v_count_next = (v_count_reg == V_LAST) ? 10'd0 : v_count_reg + 10'd1;
      end else begin
        h_count_next = h_count_reg + 10'd1;
      end
    end
  end

  // Sync decode looks at the next counter values so the sync edges line up
  // with the counter update rather than trailing it by a clock.
  always_comb begin
    hsync_next = !((h_count_next >= HS_START) && (h_count_next <= HS_END));
    vsync_next = !((v_count_next >= VS_START) && (v_count_next <= VS_END));
  end

  assign video_on = (h_count_reg < H_VIS) && (v_count_reg < V_VIS);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign rgb_next[gi] = video_on & sw[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg   <= 1'b0;
      h_count_reg <= '0;
      v_count_reg <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= 3'b000;
    end else begin
      phase_reg   <= ~phase_reg;
      h_count_reg <= h_count_next;
      v_count_reg <= v_count_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      rgb         <= rgb_next;
    end
  end

endmodule

// File: tb/tb_vga.sv
// Bench for vga: a default-timing instance for line timing and a shrunken instance
// for whole-frame timing, both checked every clock against an arithmetic timing model.
module tb_vga;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] sw  = 3'b000;

  logic       hs_big, vs_big, hs_sml, vs_sml;
  logic [2:0] rgb_big, rgb_sml;

  int tests  = 0;
  int failed = 0;
  int n      = 0;   // rising edges since reset release

  int big_fall1, big_rise1, big_fall2;
  int sml_fall1, sml_rise1, sml_fall2;
  logic big_hs_prev, sml_vs_prev;

  always #5 clk = ~clk;

  vga dut_big (
    .clk(clk), .reset(rst), .sw(sw),
    .hsync(hs_big), .vsync(vs_big), .rgb(rgb_big)
  );

  vga #(
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_sml (
    .clk(clk), .reset(rst), .sw(sw),
    .hsync(hs_sml), .vsync(vs_sml), .rgb(rgb_sml)
  );

  // Expected {hsync, vsync, rgb} after n edges, from pixel arithmetic only.
  function automatic logic [4:0] model(input int edges, input int hd, input int hf,
                                       input int hs, input int hb, input int vd,
                                       input int vf, input int vs, input int vb,
                                       input logic [2:0] s, input logic in_rst);
    int ht, vt, t, h, v, hp, vp;
    logic hsy, vsy;
    logic [2:0] c;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    if (in_rst) return {1'b1, 1'b1, 3'b000};
    t = edges / 2;
    h = t % ht;
    v = (t / ht) % vt;
    hsy = !(h >= hd + hf && h < hd + hf + hs);
    vsy = !(v >= vd + vf && v < vd + vf + vs);
    c = 3'b000;
    if (edges > 0) begin
      t  = (edges - 1) / 2;
      hp = t % ht;
      vp = (t / ht) % vt;
      if (hp < hd && vp < vd) c = s;
    end
    return {hsy, vsy, c};
  endfunction

  task automatic cmp(input string tag, input logic [4:0] got, input logic [4:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s n=%0d got=%b exp=%b", tag, n, got, exp);
    end
  endtask

  task automatic cmp_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    cmp("big", {hs_big, vs_big, rgb_big},
        model(n, 640, 16, 96, 48, 480, 10, 2, 33, sw, rst));
    cmp("sml", {hs_sml, vs_sml, rgb_sml},
        model(n, 16, 2, 4, 2, 12, 2, 2, 3, sw, rst));
    if (!rst) begin
      if (big_hs_prev && !hs_big) begin
        if (big_fall1 < 0) big_fall1 = n; else if (big_fall2 < 0) big_fall2 = n;
      end
      if (!big_hs_prev && hs_big && big_rise1 < 0) big_rise1 = n;
      if (sml_vs_prev && !vs_sml) begin
        if (sml_fall1 < 0) sml_fall1 = n; else if (sml_fall2 < 0) sml_fall2 = n;
      end
      if (!sml_vs_prev && vs_sml && sml_rise1 < 0) sml_rise1 = n;
    end
    big_hs_prev = hs_big;
    sml_vs_prev = vs_sml;
  endtask

  task automatic clear_edges();
    big_fall1 = -1; big_rise1 = -1; big_fall2 = -1;
    sml_fall1 = -1; sml_rise1 = -1; sml_fall2 = -1;
    big_hs_prev = 1'b1;
    sml_vs_prev = 1'b1;
  endtask

  // Advance one clock: count the edge if out of reset, then check at the falling edge.
  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      if (!rst) n++;
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic random_sw_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 199) == 0) sw = 3'($urandom_range(0, 7));
      run(1);
    end
  endtask

  task automatic check_edges();
    cmp_int("hsync_first_fall", big_fall1, 1312);
    cmp_int("hsync_low_end", big_rise1, 1312 + 192);
    cmp_int("hsync_period", big_fall2 - big_fall1, 1600);
    cmp_int("vsync_first_fall_small", sml_fall1, 14 * 24 * 2);
    cmp_int("vsync_low_end_small", sml_rise1, 14 * 24 * 2 + 96);
    cmp_int("vsync_period_small", sml_fall2 - sml_fall1, 19 * 24 * 2);
  endtask

  initial begin
    clear_edges();
    sw = 3'b111;
    #1 rst = 1'b1;
    #1;
    cmp("reset_no_clk_big", {hs_big, vs_big, rgb_big}, 5'b11_000);
    cmp("reset_no_clk_sml", {hs_sml, vs_sml, rgb_sml}, 5'b11_000);
    $display("[TB] reset held without clock edges");

    run(3);
    sw = 3'b101;
    rst = 1'b0;
    n = 0;
    $display("[TB] reset released, sw=101");
    run(1);
    cmp("rgb_first_edge", {2'b00, rgb_big}, {2'b00, 3'b101});
    run(600);
    sw = 3'b001;
    run(50);
    sw = 3'b110;
    run(1);
    cmp("sw_change_next_edge", {2'b00, rgb_big}, {2'b00, 3'b110});
    $display("[TB] sw 001->110 mid-line, rgb=%b", rgb_big);
    run(1281 - n);
    cmp("rgb_blank_h640", {2'b00, rgb_big}, 5'b00_000);
    random_sw_run(3300 - n);
    check_edges();
    $display("[TB] line/frame timing measured: hfall=%0d vfall_small=%0d", big_fall1, sml_fall1);

    sw = 3'b011;
    random_sw_run(200);
    sw = 3'b011;
    run(1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("midframe_reset_big", {hs_big, vs_big, rgb_big}, 5'b11_000);
    cmp("midframe_reset_sml", {hs_sml, vs_sml, rgb_sml}, 5'b11_000);
    $display("[TB] reset asserted mid-frame");
    @(negedge clk);
    run(4);
    clear_edges();
    sw = 3'b101;
    rst = 1'b0;
    n = 0;
    $display("[TB] reset released again");
    run(1);
    cmp("rgb_first_edge_2", {2'b00, rgb_big}, {2'b00, 3'b101});
    random_sw_run(3299);
    check_edges();
    $display("[TB] timing after second release: hfall=%0d", big_fall1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
